// File: rtl/uart_rx7.sv
// uart_rx7: 7-bit UART receiver (start, 7 data LSB first, parity slot, stop) with mid-bit sampling.
// Ports:
//    i_clk        - system clock, rising edge
//    i_rst        - asynchronous active-low reset
//    i_rxd        - asynchronous serial line, idle high
//    o_data       - last good received word, held until the next good frame
//    o_valid      - one-cycle pulse when o_data updates
//    o_frame_err  - one-cycle pulse when the stop bit samples low
//    o_parity_err - one-cycle pulse on even-parity mismatch (constant 0 without UART_RX7_PARITY_EN)
//    o_busy       - high whenever the receiver is not idle
// Build option: define UART_RX7_PARITY_EN to check even parity over the data bits.
module uart_rx7 #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 5
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rxd,
   output logic [6:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_parity_err,
   output logic       o_busy
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
   localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
   state_t           state_q;
   logic [1:0]       sync_q;
   logic [CNT_W-1:0] timer_q;
   logic [2:0]       idx_q;
   logic [6:0]       shift_q;
   logic             perr_q;
   logic             rxs;
   logic             tick;
   assign rxs  = sync_q[1];
   assign tick = timer_q == FULL;
   always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) begin
         state_q      <= IDLE;
         sync_q       <= 2'b11;
         timer_q      <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         perr_q       <= 1'b0;
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_frame_err  <= 1'b0;
         o_parity_err <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         sync_q       <= {sync_q[0], i_rxd};
         o_valid      <= 1'b0;
         o_frame_err  <= 1'b0;
         o_parity_err <= 1'b0;
         timer_q      <= timer_q + 1'b1;
         case (state_q)
            IDLE: begin
               timer_q <= '0;
               if (!rxs) begin
                  state_q <= START;
                  o_busy  <= 1'b1;
               end
            end
            START:
               if (timer_q == HALF) begin
                  timer_q <= '0;
                  idx_q   <= '0;
                  // a start bit that is high again at mid-bit was a glitch
                  if (rxs) begin
                     state_q <= IDLE;
                     o_busy  <= 1'b0;
                  end else
                     state_q <= DATA;
               end
            DATA:
               if (tick) begin
                  timer_q <= '0;
                  // LSB arrives first, so after seven right shifts it sits in bit 0
                  shift_q <= {rxs, shift_q[6:1]};
                  idx_q   <= idx_q + 3'd1;
                  if (idx_q == 3'd6) state_q <= PARITY;
               end
            PARITY:
               if (tick) begin
                  timer_q <= '0;
`ifdef UART_RX7_PARITY_EN
                  perr_q  <= rxs ^ (^shift_q);
`endif
                  state_q <= STOP;
               end
            STOP:
               if (tick) begin
                  timer_q <= '0;
                  if (!rxs) begin
                     o_frame_err <= 1'b1;
                     state_q     <= WAIT_IDLE;
                  end else begin
                     o_busy  <= 1'b0;
                     state_q <= IDLE;
                     if (perr_q)
                        o_parity_err <= 1'b1;
                     else begin
                        o_valid <= 1'b1;
                        o_data  <= shift_q;
                     end
                  end
               end
            WAIT_IDLE: begin
               // hold off through a break so its low level is not taken as a start bit
               timer_q <= '0;
               if (rxs) begin
                  state_q <= IDLE;
                  o_busy  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_uart_rx7.sv
// tb_uart_rx7: self-checking bench for uart_rx7 with directed vectors, corner sequences and random frames.
module tb_uart_rx7;
   localparam int CPB = 8;
   localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`ifdef UART_RX7_PARITY_EN
   localparam bit PE = 1'b1;
`else
   localparam bit PE = 1'b0;
`endif
   logic       i_clk = 1'b0;
   logic       i_rst = 1'b0;
   logic       i_rxd = 1'b1;
   logic [6:0] o_data;
   logic       o_valid, o_frame_err, o_parity_err, o_busy;
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   int         mon_n;
   logic [6:0] prev_data = '0;
   logic [6:0] model_data = '0;
   typedef struct {int kind; logic [6:0] data; int cyc;} ev_t;
   typedef struct {
      logic [6:0] d; logic p; logic stop; int gap;
      int kind_np; int kind_pe; logic [6:0] data_np; logic [6:0] data_pe;
   } vec_t;
   ev_t  act_q[$];
   ev_t  exp_q[$];
   vec_t tbl[10];
   uart_rx7 #(.CLKS_PER_BIT(CPB), .CNT_W(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_rxd(i_rxd), .o_data(o_data), .o_valid(o_valid),
      .o_frame_err(o_frame_err), .o_parity_err(o_parity_err), .o_busy(o_busy)
   );
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   always @(negedge i_clk) begin
      mon_n = int'(o_valid) + int'(o_frame_err) + int'(o_parity_err);
      if (mon_n != 0) begin
         chk("pulse_exclusive", mon_n, 1);
         act_q.push_back('{o_valid ? 1 : o_frame_err ? 2 : 3, o_data, cyc});
      end
      if (i_rst && o_data != prev_data) chk("data_change_with_valid", int'(o_valid), 1);
      prev_data = o_data;
   end
   task automatic wait_cyc(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask
   task automatic idle(input int n);
      i_rxd = 1'b1;
      wait_cyc(n);
   endtask
   task automatic send_frame(input logic [6:0] d, input logic p, input logic stop);
      int t;
      int kind;
      t = cyc;
      i_rxd = 1'b0;
      wait_cyc(CPB);
      for (int k = 0; k < 7; k++) begin
         i_rxd = d[k];
         wait_cyc(CPB);
      end
      i_rxd = p;
      wait_cyc(CPB);
      i_rxd = stop;
      wait_cyc(CPB);
      kind = !stop ? 2 : (PE && (p != ^d)) ? 3 : 1;
      if (kind == 1) model_data = d;
      exp_q.push_back('{kind, model_data, t + LAT});
   endtask
   task automatic check_events();
      ev_t e;
      ev_t a;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (act_q.size() == 0) chk("event_missing", 0, e.kind);
         else begin
            a = act_q.pop_front();
            chk("event_kind", a.kind, e.kind);
            chk("event_data", int'(a.data), int'(e.data));
            chk("event_cycle", a.cyc, e.cyc);
         end
      end
      chk("extra_events", act_q.size(), 0);
      act_q.delete();
   endtask
   task automatic chk_all_zero(input string name);
      chk({name, "_data"}, int'(o_data), 0);
      chk({name, "_pulses"}, int'({o_valid, o_frame_err, o_parity_err}), 0);
      chk({name, "_busy"}, int'(o_busy), 0);
   endtask
   initial begin
      logic [6:0] d;
      logic       p, stop;
      int         gap, hold;
      tbl[0] = '{7'h41, 1'b0, 1'b1, 10, 1, 1, 7'h41, 7'h41};
      tbl[1] = '{7'h7F, 1'b0, 1'b0, 10, 2, 2, 7'h41, 7'h41};
      tbl[2] = '{7'h12, 1'b0, 1'b1, 0,  1, 1, 7'h12, 7'h12};
      tbl[3] = '{7'h01, 1'b0, 1'b1, 0,  1, 3, 7'h01, 7'h12};
      tbl[4] = '{7'h7E, 1'b0, 1'b1, 0,  1, 1, 7'h7E, 7'h7E};
      tbl[5] = '{7'h2A, 1'b1, 1'b1, 5,  1, 1, 7'h2A, 7'h2A};
      tbl[6] = '{7'h03, 1'b0, 1'b1, 5,  1, 1, 7'h03, 7'h03};
      tbl[7] = '{7'h07, 1'b0, 1'b1, 5,  1, 3, 7'h07, 7'h03};
      tbl[8] = '{7'h00, 1'b0, 1'b0, 6,  2, 2, 7'h07, 7'h03};
      tbl[9] = '{7'h55, 1'b0, 1'b1, 5,  1, 1, 7'h55, 7'h55};
      wait_cyc(3);
      chk_all_zero("reset");
      i_rst = 1'b1;
      idle(5);
      chk("idle_busy", int'(o_busy), 0);
      for (int i = 0; i < 10; i++) begin
         send_frame(tbl[i].d, tbl[i].p, tbl[i].stop);
         chk("tbl_kind", act_q.size() > 0 ? act_q[$].kind : 0, PE ? tbl[i].kind_pe : tbl[i].kind_np);
         chk("tbl_data", int'(o_data), int'(PE ? tbl[i].data_pe : tbl[i].data_np));
         check_events();
         if (tbl[i].stop) begin
            chk("tbl_busy_after", int'(o_busy), 0);
            if (tbl[i].gap > 0) idle(tbl[i].gap);
         end else begin
            i_rxd = 1'b0;
            wait_cyc(20);
            chk("break_busy", int'(o_busy), 1);
            chk("break_no_restart", act_q.size(), 0);
            idle(tbl[i].gap);
            chk("break_released", int'(o_busy), 0);
         end
      end
      i_rxd = 1'b0;
      wait_cyc(2);
      i_rxd = 1'b1;
      chk("glitch_busy_t0", int'(o_busy), 0);
      wait_cyc(1);
      chk("glitch_busy_rise", int'(o_busy), 1);
      wait_cyc(3);
      chk("glitch_busy_hold", int'(o_busy), 1);
      wait_cyc(1);
      chk("glitch_busy_fall", int'(o_busy), 0);
      wait_cyc(10);
      check_events();
      chk("glitch_data", int'(o_data), int'(model_data));
      i_rxd = 1'b0;
      wait_cyc(CPB);
      i_rxd = 1'b1;
      wait_cyc(2 * CPB);
      i_rxd = 1'b0;
      wait_cyc(11);
      chk("midframe_busy", int'(o_busy), 1);
      i_rst = 1'b0;
      i_rxd = 1'b1;
      #1;
      chk_all_zero("async_reset");
      wait_cyc(3);
      i_rst = 1'b1;
      model_data = '0;
      chk_all_zero("after_reset");
      idle(5);
      check_events();
      send_frame(7'h55, 1'b0, 1'b1);
      check_events();
      chk("post_reset_data", int'(o_data), 'h55);
      idle(3);
      for (int i = 0; i < 40; i++) begin
         d    = 7'($urandom_range(0, 127));
         p    = 1'($urandom_range(0, 1));
         stop = $urandom_range(0, 7) != 0;
         gap  = $urandom_range(0, 3);
         hold = $urandom_range(0, 12);
         send_frame(d, p, stop);
         check_events();
         if (stop) begin
            chk("rand_busy_after", int'(o_busy), 0);
            if (gap > 0) idle(gap);
         end else begin
            i_rxd = 1'b0;
            if (hold > 0) wait_cyc(hold);
            idle(4 + gap);
            chk("rand_break_released", int'(o_busy), 0);
         end
      end
      idle(10);
      check_events();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_rx7.md
# uart_rx7

UART receiver for the 7-bit-data serial link: start bit, 7 data bits LSB first, one parity-position bit, one stop bit. It samples an asynchronous serial line with a system clock, recovers each frame by mid-bit sampling and presents the data word with a single-cycle valid strobe. It is the receiving end of the link driven by the team's UART transmitter, and feeds the command and display-update logic.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 16: i_clk cycles per bit period. Must be ≥ 4.
- `CNT_W`, default 5: bit-timer width. Must satisfy 2^CNT_W > CLKS_PER_BIT.

**Ports**
- `i_clk`, input, 1: system clock. All logic is rising-edge.
- `i_rst`, input, 1: asynchronous, active-low reset. Clock is i_clk.
- `i_rxd`, input, 1: serial line, asynchronous. Idle level is 1.
- `o_data`, output, 7: last good received word. Held until the next good frame.
- `o_valid`, output, 1: one-cycle pulse when o_data updates.
- `o_frame_err`, output, 1: one-cycle pulse when the stop bit is sampled as 0.
- `o_parity_err`, output, 1: one-cycle pulse on parity mismatch. Tied 0 when parity checking is compiled out.
- `o_busy`, output, 1: high in every state except IDLE.

## Operation

- **Input synchronizer:** i_rxd passes through a 2-flop synchronizer that resets to 1. Call the output rxs. All decisions use rxs only.
- **Reset values:** state=IDLE, o_data=0, o_valid=0, o_frame_err=0, o_parity_err=0, o_busy=0, bit timer=0, bit index=0.
- **States:** IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- **IDLE:** when rxs=0, go to START and load timer=0.
- **START:** at timer = CLKS_PER_BIT/2 − 1 (integer division), sample rxs.
  - If rxs=1, treat it as a glitch: return to IDLE with no output pulse.
  - Otherwise clear the timer and go to DATA with index 0.
- **DATA:** at timer = CLKS_PER_BIT − 1, shift rxs into shift[index], clear the timer and increment the index. After index 6 is sampled, go to PARITY.
- **PARITY:** at timer = CLKS_PER_BIT − 1, capture the parity bit p, then go to STOP.
- **STOP:** at timer = CLKS_PER_BIT − 1, sample rxs.
  - If rxs=1 and there is no parity error, o_data ← shift and pulse o_valid. Go to IDLE.
  - If rxs=1 with a parity error, pulse o_parity_err, leave o_data unchanged and go to IDLE.
  - If rxs=0, pulse o_frame_err (o_parity_err is not pulsed), leave o_data unchanged and go to WAIT_IDLE.
- **WAIT_IDLE:** stay until rxs=1, then go to IDLE. This rejects break conditions and prevents a false start.
- **Back-to-back frames:** a start edge in the cycle directly after the STOP sample is accepted. There is no idle gap requirement.
- **Reset mid-frame:** all state clears at once, o_data returns to 0 and no pulse is emitted. After reset the line must be seen at rxs=1 before a new start is accepted, which the IDLE entry condition guarantees.
- **Output exclusivity:** o_valid, o_frame_err and o_parity_err are never high in the same cycle.

## Timing

- Let t0 be the first cycle in which rxs=0 is seen in IDLE.
- Sample points:
  - start bit at t0 + CLKS_PER_BIT/2
  - data bit k at t0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT
  - parity bit at t0 + CLKS_PER_BIT/2 + 8·CLKS_PER_BIT
  - stop bit at t0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT
- o_valid, o_frame_err and o_parity_err are registered and go high the cycle after the stop sample. The o_data update happens in the same cycle as o_valid.
- Pin-to-valid latency is 2 synchronizer cycles + 9.5 bit periods + 1 cycle.
- o_busy rises the cycle after t0 and falls on the cycle the FSM re-enters IDLE.
- Tolerated transmitter clock mismatch is ±4% at the default CLKS_PER_BIT.

## Configuration

- **`UART_RX7_PARITY_EN` defined:** p must equal ^shift, i.e. even parity over the 7 data bits. A mismatch pulses o_parity_err and suppresses o_valid.
- **Not defined:** p is sampled and discarded, o_parity_err is constant 0 and any parity-position value is accepted. This matches the current transmitter, which sends a constant 0 in that slot.

## Test plan

All scenarios use CLKS_PER_BIT=8.

1. **Reset values:** assert i_rst low mid-frame for 3 cycles, then release → every output is 0, o_busy=0, and the next clean frame 0x55 is received correctly.
2. **Good frame:** send 0x41 with parity slot 0 and stop=1 (macro undefined) → o_valid pulses exactly once, 1 cycle wide, at 2+76+1 cycles after the falling edge on i_rxd. o_data=0x41.
3. **Glitch rejection:** pulse i_rxd low for 2 cycles → o_busy rises, then the FSM returns to IDLE with no pulse and o_data unchanged.
4. **Framing error:** send 0x7F with stop=0 and hold the line low for 20 more cycles → o_frame_err pulses once, o_data keeps its previous value, no new frame starts until i_rxd returns high, then 0x12 is received correctly.
5. **Back-to-back:** send 0x01, 0x7E and 0x2A with no idle gap → three o_valid pulses 80 cycles apart, with o_data = 0x01, 0x7E, 0x2A in order.
6. **Parity checking** (macro defined):
   - send 0x03 with p=0 → o_valid, o_data=0x03
   - send 0x07 with p=0 → o_parity_err pulse, o_data stays 0x03
